// File: rtl/debounce_pkg.sv
// Shared types for the debounce_edge block: FSM state encoding and edge-counter width.
package debounce_pkg;

  localparam int EDGE_CNT_W = 8;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/debounce_edge.sv
// Debouncer with registered level plus one-cycle rise/fall pulses.
// Optional accepted-rise counter on edge_cnt when DEBOUNCE_EDGE_CNT_EN is defined.
//   state     | meaning
//   LOW       | level 0, input agrees
//   WAIT_HIGH | level 0, counting consecutive 1 samples
//   HIGH      | level 1, input agrees
//   WAIT_LOW  | level 1, counting consecutive 0 samples
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
`ifdef DEBOUNCE_EDGE_CNT_EN
  ,
  output logic [EDGE_CNT_W-1:0] edge_cnt
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      LOW: begin
        if (d_in) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!d_in) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (!d_in) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (d_in) begin
          state_d = HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] edge_cnt_q;

  // Advances on the same edge that raises the rise pulse, so both are visible together.
  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt_q <= '0;
    end else if (rise_d) begin
      edge_cnt_q <= edge_cnt_q + EDGE_CNT_W'(1);
    end
  end

  assign edge_cnt = edge_cnt_q;
`else
  // Counter not built; edge_cnt port is absent.
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge against a run-length reference model.
module tb_debounce_edge;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic reset;
  logic d_in;
  logic level;
  logic rise;
  logic fall;
`ifdef DEBOUNCE_EDGE_CNT_EN
  logic [7:0] edge_cnt;
  int unsigned m_edges;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted level plus length of the current run of opposite samples.
  bit m_level;
  int m_run;
  bit m_rise;
  bit m_fall;

  always #10 clk = ~clk;

  debounce_edge #(.STABLE_CYCLES(SC)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
`ifdef DEBOUNCE_EDGE_CNT_EN
    ,
    .edge_cnt (edge_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit d, input bit r);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      m_level = 1'b0;
      m_run   = 0;
`ifdef DEBOUNCE_EDGE_CNT_EN
      m_edges = 0;
`endif
    end else if (d != m_level) begin
      m_run++;
      if (m_run == SC) begin
        m_level = d;
        m_run   = 0;
        if (d) begin
          m_rise = 1'b1;
`ifdef DEBOUNCE_EDGE_CNT_EN
          m_edges = (m_edges + 1) % 256;
`endif
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input bit d, input bit r);
    d_in  = d;
    reset = r;
    @(posedge clk);
    model_update(d, r);
    #1;
    chk("level", {31'd0, level}, {31'd0, m_level});
    chk("rise", {31'd0, rise}, {31'd0, m_rise});
    chk("fall", {31'd0, fall}, {31'd0, m_fall});
`ifdef DEBOUNCE_EDGE_CNT_EN
    chk("edge_cnt", {24'd0, edge_cnt}, m_edges);
`endif
  endtask

  initial begin
    int rise_at;
    int fall_at;
    int n_fall;
    bit seen;
    bit d;
    bit r;

    reset   = 1'b1;
    d_in    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
`ifdef DEBOUNCE_EDGE_CNT_EN
    m_edges = 0;
`endif

    // Input held high through reset release: rise on the SC-th free edge.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    rise_at = 0;
    seen    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (rise && rise_at == 0) rise_at = i;
      if (fall) seen = 1'b1;
    end
    chk("rise_edge", rise_at, SC);
    chk("fall_after_reset", {31'd0, seen}, 0);
    chk("level_high", {31'd0, level}, 1);

    // Short low glitch from HIGH is rejected.
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      if (fall) seen = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      if (fall) seen = 1'b1;
    end
    chk("glitch_low_fall", {31'd0, seen}, 0);
    chk("glitch_low_level", {31'd0, level}, 1);

    // Held low: exactly one fall on the SC-th edge.
    fall_at = 0;
    n_fall  = 0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0);
      if (fall) begin
        n_fall++;
        if (fall_at == 0) fall_at = i;
      end
    end
    chk("fall_edge", fall_at, SC);
    chk("fall_count", n_fall, 1);
    chk("level_low", {31'd0, level}, 0);

    // Toggling every cycle never qualifies.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(i[0] ? 1'b0 : 1'b1, 1'b0);
      if (level || rise || fall) seen = 1'b1;
    end
    chk("toggle_quiet", {31'd0, seen}, 0);
    step(1'b0, 1'b0);

    // Reset lands on the qualifying edge: no rise, partial count discarded.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("rst_qual_rise", {31'd0, rise}, 0);
    chk("rst_qual_level", {31'd0, level}, 0);
`ifdef DEBOUNCE_EDGE_CNT_EN
    chk("rst_qual_cnt", {24'd0, edge_cnt}, 0);
`endif
    rise_at = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0);
      if (rise && rise_at == 0) rise_at = i;
    end
    chk("restart_rise_edge", rise_at, SC);

    // Randomised run with sticky input and rare resets.
    d = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 25) d = ~d;
      r = ($urandom_range(0, 199) == 0);
      step(d, r);
    end

`ifdef DEBOUNCE_EDGE_CNT_EN
    // 257 accepted rises wrap the 8-bit counter to 1.
    step(1'b0, 1'b1);
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < SC; i++) step(1'b1, 1'b0);
      for (int i = 0; i < SC; i++) step(1'b0, 1'b0);
    end
    chk("edge_wrap", {24'd0, edge_cnt}, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive equal samples required to accept a new level; legal range 2..255.
REQ-002 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port d_in, input, 1: raw serial level; driven by q of the upstream d_ff_reset stage.
REQ-005 Port level, output, 1: debounced level of d_in.
REQ-006 Port rise, output, 1: one-cycle pulse when level goes 0->1.
REQ-007 Port fall, output, 1: one-cycle pulse when level goes 1->0.
REQ-008 Port edge_cnt, output, 8: accepted rising-edge count; present only with DEBOUNCE_EDGE_CNT_EN.

Function
REQ-009 FSM states SHALL be LOW, WAIT_HIGH, HIGH, WAIT_LOW; counter cnt SHALL be $clog2(STABLE_CYCLES+1) bits wide.
REQ-010 LOW: d_in=1 -> WAIT_HIGH, cnt<=1; d_in=0 -> stay in LOW.
REQ-011 WAIT_HIGH: d_in=0 -> LOW, cnt<=0 (glitch rejected, no pulse); d_in=1 with cnt=STABLE_CYCLES-1 -> HIGH, cnt<=0, level<=1, rise<=1; otherwise cnt<=cnt+1.
REQ-012 HIGH: d_in=0 -> WAIT_LOW, cnt<=1; d_in=1 -> stay in HIGH.
REQ-013 WAIT_LOW: d_in=1 -> HIGH, cnt<=0, no pulse; d_in=0 with cnt=STABLE_CYCLES-1 -> LOW, cnt<=0, level<=0, fall<=1; otherwise cnt<=cnt+1.
REQ-014 Latency: level changes on the edge that samples the STABLE_CYCLES-th consecutive opposite value; rise/fall assert on that same edge.
REQ-015 rise and fall SHALL each be high for exactly one cycle and SHALL never be high together.
REQ-016 All outputs SHALL be registered; no combinational path from d_in to any output.
REQ-017 A run of fewer than STABLE_CYCLES opposite samples SHALL leave level, rise and fall unchanged.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1.

Reset
REQ-019 When reset is high at a clock edge, the next state SHALL be: state=LOW, cnt=0, level=0, rise=0, fall=0, edge_cnt=0.
REQ-020 reset SHALL take priority over every transition, including a qualifying edge on the same clock edge; no pulse is emitted.
REQ-021 Reset mid-WAIT SHALL discard partial counts; after release, qualification restarts from the first sample.
REQ-022 d_in=1 continuously through reset release SHALL yield rise STABLE_CYCLES edges after the first non-reset edge.

Configuration
REQ-023 With DEBOUNCE_EDGE_CNT_EN defined: port edge_cnt exists and increments by 1 on every rise pulse, wrapping 255->0.
REQ-024 Without DEBOUNCE_EDGE_CNT_EN: the port and its counter are absent; all other behaviour is identical.

Structure
REQ-025 Package debounce_pkg SHALL hold the state enum (LOW, WAIT_HIGH, HIGH, WAIT_LOW) and the localparam EDGE_CNT_W=8.
REQ-026 A single module SHALL implement the block; no sub-module, since the counter is internal to the FSM.

Verification (STABLE_CYCLES=4, clk period 20 ns)
REQ-027 reset high for 2 cycles, then d_in=1 held -> rise pulses on the 4th post-reset edge; level=1 from then on; fall=0 throughout.
REQ-028 From HIGH, d_in=0 for 3 cycles then 1 -> level stays 1; no fall pulse.
REQ-029 From HIGH, d_in=0 held 5 cycles -> fall pulses once on the 4th edge; level=0.
REQ-030 d_in toggles every cycle for 20 cycles from LOW -> level=0, rise=0, fall=0 throughout.
REQ-031 In WAIT_HIGH with cnt=3, reset asserted on the qualifying edge -> no rise; level=0; edge_cnt=0.
REQ-032 With DEBOUNCE_EDGE_CNT_EN: 257 qualified rise events -> edge_cnt=1 (wrapped); without the macro, the bench compiles without the edge_cnt port.
